scan_reg_file_mp: RTL and testbench
===================================

// Module: scan_reg_file_mp
//
// PURPOSE
// Multi-read-port, single-write-port register file with a serial scan/debug port. Serves the
// pipeline's operand reads and write-back; a scan FSM dumps (shift-out) or loads (shift-in) the
// whole array bit-serially for debug and test. Optional write-to-read bypass and hardwired zero
// register. Next generation of the scan register file unit.
//
// PARAMETERS
// WIDTH     32  bits per register
// SIZE      8   number of registers (power of 2, >=2); AW = $clog2(SIZE)
// RD_PORTS  2   number of read ports (1..4)
// ZERO_REG  1   1: register 0 always reads 0, writes to it are discarded
// BYPASS    1   1: same-cycle write data forwarded to matching read ports
//
// PORTS
// clk       in   1              clock, all state updates on rising edge
// rst       in   1              asynchronous, active-low reset
// write     in   1              functional write enable
// wrAddr    in   AW             write address
// wrData    in   WIDTH          write data
// rdAddr    in   RD_PORTS*AW    read addresses, port p at [p*AW +: AW]
// rdData    out  RD_PORTS*WIDTH read data, port p at [p*WIDTH +: WIDTH], combinational
// scanStart in   1              start scan operation (sampled in IDLE only)
// scanMode  in   1              0 = shift-out (dump), 1 = shift-in (load); latched at start
// scanAbort in   1              abort active scan
// scanIn    in   1              serial input, sampled every SHIFT cycle in shift-in mode
// scanOut   out  1              serial output, valid every SHIFT cycle in shift-out mode
// scanBusy  out  1              high while FSM in SHIFT
// scanDone  out  1              one-cycle pulse on normal completion
// wrIgnored out  1              one-cycle pulse: functional write dropped due to scan
//
// BEHAVIOUR
// - Reset (rst=0, async): all registers 0, FSM IDLE, counters 0, shadow 0; scanOut, scanBusy,
//   scanDone, wrIgnored = 0. Reset mid-scan aborts immediately; array cleared.
// - Read: rdData[p] = reg[rdAddr[p]], zero latency. ZERO_REG=1 and addr 0 -> 0 (overrides bypass).
// - Bypass (BYPASS=1): write=1, not busy, wrAddr==rdAddr[p] -> rdData[p]=wrData same cycle.
//   BYPASS=0 -> old value until the next edge.
// - Write: reg[wrAddr] <= wrData on edge when write=1 and FSM IDLE. Write while SHIFT (or in the
//   cycle scanStart is accepted) is dropped; wrIgnored pulses the next cycle.
// - FSM states: IDLE -> SHIFT on scanStart; SHIFT -> DONE after SIZE*WIDTH bit cycles;
//   DONE -> IDLE next cycle (scanDone=1 in DONE). scanAbort in SHIFT -> IDLE next edge, no scanDone.
// - Counters: bitCnt 0..WIDTH-1, regCnt 0..SIZE-1; bitCnt wraps to 0 and regCnt++ at word end.
//   Chain order: reg 0 first, within a register bit 0 (MSB, [0:WIDTH-1]) first.
// - Shift-out: on start the shadow loads reg[0]; scanOut = shadow[0] during SHIFT; shadow shifts
//   each cycle; at word end it reloads reg[regCnt+1]. Chain bit k appears in cycle start+1+k.
//   Total SIZE*WIDTH cycles; scanOut=0 outside SHIFT. Array unchanged.
// - Shift-in: scanIn shifted into shadow LSB each SHIFT cycle; at word end reg[regCnt] <= the
//   assembled word (reg 0 discarded if ZERO_REG=1). Abort: completed words kept, partial word
//   discarded.
// - scanStart while busy/DONE ignored; scanAbort in IDLE ignored; reads stay functional during scan.
//
// TESTING
// 1 Reset: write 0xDEADBEEF to r3, pulse rst=0 -> all reads 0, scanBusy=0, scanOut=0.
// 2 Write/read/bypass: write r5=0x12345678, rdAddr p0=5 same cycle -> 0x12345678 (BYPASS=1);
//   BYPASS=0 -> old 0, new value next cycle; write r0=0xFFFFFFFF, read r0 -> 0 (ZERO_REG=1).
// 3 Shift-out: r1=0x80000001, others 0, start mode 0 -> scanOut=1 at cycles 33 and 64 only,
//   scanDone pulse at cycle 257 (SIZE=8, WIDTH=32), array unchanged.
// 4 Shift-in: mode 1, stream r1=0xA5A5A5A5, r7=0x0000FFFF -> reads return them after scanDone;
//   r0 reads 0.
// 5 Abort: mode 1, scanAbort after 40 bits -> r1 unchanged, IDLE next cycle, no scanDone;
//   write during scan -> dropped, wrIgnored pulse.
// 6 Async reset at bit 100 of shift-out -> scanBusy=0 immediately, array 0, no scanDone.

Source files
------------

// File: rtl/scan_reg_file_mp_if.sv
// Functional read/write and scan-port signals of the scan register file.
// The master drives the i_* signals; the register file (slave) drives the o_* signals.
interface scan_reg_file_mp_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SIZE     = 8,
    parameter int unsigned RD_PORTS = 2
);
    localparam int unsigned AW = $clog2(SIZE);

    logic                         i_write;
    logic [AW-1:0]                i_wr_addr;
    logic [WIDTH-1:0]             i_wr_data;
    logic [RD_PORTS*AW-1:0]       i_rd_addr;
    logic [RD_PORTS*WIDTH-1:0]    o_rd_data;
    logic                         i_scan_start;
    logic                         i_scan_mode;
    logic                         i_scan_abort;
    logic                         i_scan_in;
    logic                         o_scan_out;
    logic                         o_scan_busy;
    logic                         o_scan_done;
    logic                         o_wr_ignored;

    modport master (
        output i_write, i_wr_addr, i_wr_data, i_rd_addr,
        output i_scan_start, i_scan_mode, i_scan_abort, i_scan_in,
        input  o_rd_data, o_scan_out, o_scan_busy, o_scan_done, o_wr_ignored
    );

    modport slave (
        input  i_write, i_wr_addr, i_wr_data, i_rd_addr,
        input  i_scan_start, i_scan_mode, i_scan_abort, i_scan_in,
        output o_rd_data, o_scan_out, o_scan_busy, o_scan_done, o_wr_ignored
    );
endinterface

// File: rtl/scan_reg_file_mp.sv
// Multi-read, single-write register file with a bit-serial scan port that dumps or loads the
// whole array, register 0 first and MSB first within each register. Requires WIDTH >= 2.
module scan_reg_file_mp #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SIZE     = 8,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    scan_reg_file_mp_if.slave   bus
);
    localparam int unsigned AW = $clog2(SIZE);
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           r_state;
    logic             r_mode;
    logic             r_busy;
    logic             r_done;
    logic             r_wr_ignored;
    logic [BW-1:0]    r_bit_cnt;
    logic [AW-1:0]    r_reg_cnt;
    logic [0:WIDTH-1] r_shadow;
    logic [0:WIDTH-1] r_regs [SIZE];

    logic             w_wr_en;
    logic             w_wr_drop;
    logic             w_wr_zero;
    logic             w_word_end;
    logic             w_last_reg;
    logic             w_scan_zero;
    logic [0:WIDTH-1] w_shift_word;
    logic [RD_PORTS*WIDTH-1:0] w_rd_data;

    // A write in the cycle a scan is accepted is dropped along with writes during the scan.
    assign w_wr_en      = bus.i_write && (r_state == StIdle) && !bus.i_scan_start;
    assign w_wr_drop    = bus.i_write && !w_wr_en;
    assign w_wr_zero    = (ZERO_REG != 0) && (bus.i_wr_addr == '0);
    assign w_word_end   = (r_bit_cnt == BW'(WIDTH - 1));
    assign w_last_reg   = (r_reg_cnt == AW'(SIZE - 1));
    assign w_scan_zero  = (ZERO_REG != 0) && (r_reg_cnt == '0);
    assign w_shift_word = {r_shadow[1:WIDTH-1], bus.i_scan_in};

    always_comb begin : read_ports
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] word;
        w_rd_data = '0;
        addr      = '0;
        word      = '0;
        for (int p = 0; p < int'(RD_PORTS); p++) begin
            addr = bus.i_rd_addr[p*AW +: AW];
            word = r_regs[addr];
            if ((BYPASS != 0) && bus.i_write && !r_busy && (bus.i_wr_addr == addr)) begin
                word = bus.i_wr_data;
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                word = '0;
            end
            w_rd_data[p*WIDTH +: WIDTH] = word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_mode       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wr_ignored <= 1'b0;
            r_bit_cnt    <= '0;
            r_reg_cnt    <= '0;
            r_shadow     <= '0;
            for (int unsigned i = 0; i < SIZE; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_ignored <= w_wr_drop;
            r_done       <= 1'b0;
            if (w_wr_en && !w_wr_zero) begin
                r_regs[bus.i_wr_addr] <= bus.i_wr_data;
            end
            unique case (r_state)
                StIdle: begin
                    if (bus.i_scan_start) begin
                        r_state   <= StShift;
                        r_busy    <= 1'b1;
                        r_mode    <= bus.i_scan_mode;
                        r_bit_cnt <= '0;
                        r_reg_cnt <= '0;
                        r_shadow  <= r_regs[0];
                    end
                end
                StShift: begin
                    if (bus.i_scan_abort) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_bit_cnt <= w_word_end ? '0 : r_bit_cnt + BW'(1);
                        if (r_mode) begin
                            r_shadow <= w_shift_word;
                            if (w_word_end && !w_scan_zero) begin
                                r_regs[r_reg_cnt] <= w_shift_word;
                            end
                        end else if (w_word_end) begin
                            r_shadow <= r_regs[r_reg_cnt + AW'(1)];
                        end else begin
                            r_shadow <= {r_shadow[1:WIDTH-1], 1'b0};
                        end
                        if (w_word_end) begin
                            r_reg_cnt <= r_reg_cnt + AW'(1);
                            if (w_last_reg) begin
                                r_state <= StDone;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_rd_data    = w_rd_data;
    assign bus.o_scan_out   = r_busy && !r_mode && r_shadow[0];
    assign bus.o_scan_busy  = r_busy;
    assign bus.o_scan_done  = r_done;
    assign bus.o_wr_ignored = r_wr_ignored;

endmodule

// File: tb/tb_scan_reg_file_mp.sv
// Directed bench for scan_reg_file_mp: reset, read/write/bypass, scan dump, scan load,
// abort with dropped write, and asynchronous reset in the middle of a dump.
module tb_scan_reg_file_mp;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    scan_reg_file_mp_if #(.WIDTH(32), .SIZE(8), .RD_PORTS(2)) bus ();
    scan_reg_file_mp_if #(.WIDTH(32), .SIZE(8), .RD_PORTS(2)) bus_nb ();

    scan_reg_file_mp #(
        .WIDTH(32), .SIZE(8), .RD_PORTS(2), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    scan_reg_file_mp #(
        .WIDTH(32), .SIZE(8), .RD_PORTS(2), .ZERO_REG(1), .BYPASS(0)
    ) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb)
    );

    // Same stimulus drives the no-bypass instance.
    assign bus_nb.i_write      = bus.i_write;
    assign bus_nb.i_wr_addr    = bus.i_wr_addr;
    assign bus_nb.i_wr_data    = bus.i_wr_data;
    assign bus_nb.i_rd_addr    = bus.i_rd_addr;
    assign bus_nb.i_scan_start = bus.i_scan_start;
    assign bus_nb.i_scan_mode  = bus.i_scan_mode;
    assign bus_nb.i_scan_abort = bus.i_scan_abort;
    assign bus_nb.i_scan_in    = bus.i_scan_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
        bus.i_rd_addr = {a1, a0};
        #1;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.i_write   = 1'b1;
        bus.i_wr_addr = a;
        bus.i_wr_data = d;
        @(negedge clk);
        bus.i_write   = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] words [8];
    logic [31:0] w;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_write      = 1'b0;
        bus.i_wr_addr    = '0;
        bus.i_wr_data    = '0;
        bus.i_rd_addr    = '0;
        bus.i_scan_start = 1'b0;
        bus.i_scan_mode  = 1'b0;
        bus.i_scan_abort = 1'b0;
        bus.i_scan_in    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: reset clears array and outputs
        wr(3'd3, 32'hDEADBEEF);
        set_rd(3'd3, 3'd3);
        check_eq("t1_pre_r3", bus.o_rd_data[31:0], 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check_eq("t1_rst_r3_p0", bus.o_rd_data[31:0], 32'h0);
        check_eq("t1_rst_r3_p1", bus.o_rd_data[63:32], 32'h0);
        check_eq("t1_rst_busy", {31'b0, bus.o_scan_busy}, 32'h0);
        check_eq("t1_rst_sout", {31'b0, bus.o_scan_out}, 32'h0);
        check_eq("t1_rst_done", {31'b0, bus.o_scan_done}, 32'h0);
        check_eq("t1_rst_wign", {31'b0, bus.o_wr_ignored}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: write, same-cycle bypass, zero register
        bus.i_write   = 1'b1;
        bus.i_wr_addr = 3'd5;
        bus.i_wr_data = 32'h12345678;
        set_rd(3'd5, 3'd5);
        check_eq("t2_byp_p0", bus.o_rd_data[31:0], 32'h12345678);
        check_eq("t2_byp_p1", bus.o_rd_data[63:32], 32'h12345678);
        check_eq("t2_nobyp_p0", bus_nb.o_rd_data[31:0], 32'h0);
        @(negedge clk);
        bus.i_write = 1'b0;
        #1;
        check_eq("t2_after_byp", bus.o_rd_data[31:0], 32'h12345678);
        check_eq("t2_after_nobyp", bus_nb.o_rd_data[31:0], 32'h12345678);
        bus.i_write   = 1'b1;
        bus.i_wr_addr = 3'd0;
        bus.i_wr_data = 32'hFFFFFFFF;
        set_rd(3'd0, 3'd5);
        check_eq("t2_r0_samecyc", bus.o_rd_data[31:0], 32'h0);
        @(negedge clk);
        bus.i_write = 1'b0;
        #1;
        check_eq("t2_r0_after", bus.o_rd_data[31:0], 32'h0);
        check_eq("t2_r5_p1", bus.o_rd_data[63:32], 32'h12345678);

        // 3: shift-out dump
        pulse_reset();
        wr(3'd1, 32'h80000001);
        set_rd(3'd1, 3'd5);
        bus.i_scan_mode  = 1'b0;
        bus.i_scan_start = 1'b1;
        for (int n = 1; n <= 258; n++) begin
            @(negedge clk);
            bus.i_scan_start = 1'b0;
            check_eq($sformatf("t3_sout_c%0d", n), {31'b0, bus.o_scan_out},
                     (n == 33 || n == 64) ? 32'h1 : 32'h0);
            check_eq($sformatf("t3_busy_c%0d", n), {31'b0, bus.o_scan_busy},
                     (n >= 1 && n <= 256) ? 32'h1 : 32'h0);
            check_eq($sformatf("t3_done_c%0d", n), {31'b0, bus.o_scan_done},
                     (n == 257) ? 32'h1 : 32'h0);
        end
        check_eq("t3_r1_kept", bus.o_rd_data[31:0], 32'h80000001);
        check_eq("t3_r5_zero", bus.o_rd_data[63:32], 32'h0);

        // 4: shift-in load
        words[0] = 32'hFFFFFFFF;
        words[1] = 32'hA5A5A5A5;
        words[2] = 32'h0;
        words[3] = 32'h13579BDF;
        words[4] = 32'h0;
        words[5] = 32'h0;
        words[6] = 32'h0;
        words[7] = 32'h0000FFFF;
        bus.i_scan_mode  = 1'b1;
        bus.i_scan_start = 1'b1;
        @(negedge clk);
        bus.i_scan_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            w = words[k];
            for (int b = 0; b < 32; b++) begin
                bus.i_scan_in = w[31-b];
                #1;
                check_eq($sformatf("t4_busy_r%0d_b%0d", k, b), {31'b0, bus.o_scan_busy}, 32'h1);
                @(negedge clk);
            end
        end
        bus.i_scan_in = 1'b0;
        check_eq("t4_done", {31'b0, bus.o_scan_done}, 32'h1);
        @(negedge clk);
        check_eq("t4_done_clear", {31'b0, bus.o_scan_done}, 32'h0);
        set_rd(3'd1, 3'd7);
        check_eq("t4_r1", bus.o_rd_data[31:0], 32'hA5A5A5A5);
        check_eq("t4_r7", bus.o_rd_data[63:32], 32'h0000FFFF);
        set_rd(3'd0, 3'd3);
        check_eq("t4_r0", bus.o_rd_data[31:0], 32'h0);
        check_eq("t4_r3", bus.o_rd_data[63:32], 32'h13579BDF);

        // 5: abort after 40 bits, with a write dropped mid-scan
        set_rd(3'd1, 3'd4);
        bus.i_scan_mode  = 1'b1;
        bus.i_scan_start = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            bus.i_scan_start = 1'b0;
            bus.i_scan_in    = (n <= 40);
            bus.i_write      = (n == 20);
            bus.i_wr_addr    = 3'd4;
            bus.i_wr_data    = 32'hCAFEF00D;
            bus.i_scan_abort = (n == 41);
            #1;
            if (n == 20) check_eq("t5_no_byp_busy", bus.o_rd_data[63:32], 32'h0);
            check_eq($sformatf("t5_wign_c%0d", n), {31'b0, bus.o_wr_ignored},
                     (n == 21) ? 32'h1 : 32'h0);
            check_eq($sformatf("t5_busy_c%0d", n), {31'b0, bus.o_scan_busy},
                     (n <= 41) ? 32'h1 : 32'h0);
            check_eq($sformatf("t5_done_c%0d", n), {31'b0, bus.o_scan_done}, 32'h0);
        end
        bus.i_scan_in = 1'b0;
        check_eq("t5_r1_unchanged", bus.o_rd_data[31:0], 32'hA5A5A5A5);
        check_eq("t5_r4_dropped", bus.o_rd_data[63:32], 32'h0);

        // 6: async reset in the middle of a dump
        wr(3'd2, 32'h11111111);
        set_rd(3'd2, 3'd1);
        bus.i_scan_mode  = 1'b0;
        bus.i_scan_start = 1'b1;
        for (int n = 1; n <= 101; n++) begin
            @(negedge clk);
            bus.i_scan_start = 1'b0;
        end
        check_eq("t6_busy_before", {31'b0, bus.o_scan_busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_busy_rst", {31'b0, bus.o_scan_busy}, 32'h0);
        check_eq("t6_sout_rst", {31'b0, bus.o_scan_out}, 32'h0);
        check_eq("t6_r2_rst", bus.o_rd_data[31:0], 32'h0);
        check_eq("t6_r1_rst", bus.o_rd_data[63:32], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check_eq($sformatf("t6_done_%0d", n), {31'b0, bus.o_scan_done}, 32'h0);
            check_eq($sformatf("t6_busy_%0d", n), {31'b0, bus.o_scan_busy}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
